if_pc_fetch: RTL

- Fetch-stage PC generator; sits directly upstream of the synchronous instruction memory.
- Drives `imem_addr` each cycle, selects the next PC, and tracks the one-cycle BRAM read latency.
- Presents to the IF/ID register an aligned (`fetch_pc`, `fetch_instr`, `fetch_valid`) triple.
- Handles stall, delayed branch/jump redirect, exception entry and eret.

---
 rtl/if_pc_fetch_pkg.sv | 28 ++
 rtl/if_next_pc_sel.sv | 40 ++++
 rtl/if_pc_fetch.sv | 80 ++++++++
 3 files changed

// File: rtl/if_pc_fetch_pkg.sv
// Shared CPU constants for the fetch stage: reset/exception vectors,
// instruction memory window and the nop encoding.
package if_pc_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [XLEN-1:0] IMEM_BASE  = 32'h0000_3000;
  localparam logic [XLEN-1:0] IMEM_TOP   = 32'h0000_4FFC;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_REDIRECT,
    SEL_SEQ
  } pc_sel_e;

  // Fetch address is misaligned or outside the instruction memory window.
  function automatic logic fetch_addr_bad(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IMEM_BASE) || (addr > IMEM_TOP);
  endfunction

endpackage

// File: rtl/if_next_pc_sel.sv
// Combinational next-PC priority mux and sequential +4 adder (wraps mod 2^32).
module if_next_pc_sel
  import if_pc_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            exc_en,
  input  logic            eret_en,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] next_pc_c
);

  pc_sel_e         sel;
  logic [XLEN-1:0] pc_plus4;

  // Resolve which source feeds the PC; redirect is ignored while stalled.
  always_comb begin
    sel = SEL_SEQ;
    if (exc_en)           sel = SEL_EXC;
    else if (eret_en)     sel = SEL_ERET;
    else if (stall)       sel = SEL_HOLD;
    else if (redirect_en) sel = SEL_REDIRECT;
  end

  // Select the next PC from the chosen source.
  always_comb begin
    pc_plus4  = XLEN'(pc + PC_STEP);
    next_pc_c = pc_plus4;
    case (sel)
      SEL_EXC:      next_pc_c = EXC_VECTOR;
      SEL_ERET:     next_pc_c = epc;
      SEL_HOLD:     next_pc_c = pc;
      SEL_REDIRECT: next_pc_c = redirect_pc;
      default:      next_pc_c = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_pc_fetch.sv
// Fetch-stage PC generator in front of a one-cycle-latency instruction memory.
// Optional fetch address checking is enabled with IF_FETCH_ADDR_CHECK_EN.
module if_pc_fetch
  import if_pc_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            exc_en,
  input  logic            eret_en,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_instr,
  output logic            fetch_valid,
  output logic            fetch_adel
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d1;
  logic            valid_q;
  logic [XLEN-1:0] next_pc;
  logic            squash;
  logic            adel_c;

  if_next_pc_sel u_next_pc_sel (
    .pc          (pc_q),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .exc_en      (exc_en),
    .eret_en     (eret_en),
    .epc         (epc),
    .next_pc_c   (next_pc)
  );

  // Exception entry or return kills the read already in flight, even when stalled.
  assign squash = exc_en | eret_en;

  // PC, in-flight PC and in-flight validity; stall freezes the pipeline view.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      pc_d1   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q <= next_pc;
      if (!stall) pc_d1 <= pc_q;
      if (squash)      valid_q <= 1'b0;
      else if (!stall) valid_q <= 1'b1;
    end
  end

  assign imem_addr = pc_q;

`ifdef IF_FETCH_ADDR_CHECK_EN
  // Flag a bad fetch address; the slot stays valid so the fault reaches the exception logic.
  always_comb begin
    adel_c = valid_q & fetch_addr_bad(pc_d1);
  end
`else
  // Address checking disabled.
  always_comb begin
    adel_c = 1'b0;
  end
`endif

  // Present the aligned PC/instruction/valid triple to IF/ID.
  always_comb begin
    fetch_pc    = pc_d1;
    fetch_valid = valid_q;
    fetch_adel  = adel_c;
    fetch_instr = NOP_INSTR;
    if (valid_q && !adel_c) fetch_instr = imem_rdata;
  end

endmodule
